mmr_mismatch_monitor: RTL and testbench

Downstream consumer of the K-modular-redundant register array. It takes the array's triplicated outputs and its mismatch flag, and turns raw per-cycle mismatches into a single event count, a sticky status and a one-cycle interrupt pulse. It separates transient upsets from persistent faults and, optionally, identifies which redundant lane disagrees with the majority. It sits between the MMR register arrays and the slow-control status registers.

---
 rtl/mmr_mismatch_monitor.sv | 150 +++++++++++++++
 tb/tb_mmr_mismatch_monitor.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmr_mismatch_monitor.sv
// mmr_mismatch_monitor: event count, sticky, irq and persistence from MMR mismatches.
// Optional lane diagnosis compiled in with MMR_MONITOR_LANE_DIAG_EN.
module mmr_mismatch_monitor #(
  parameter int K_MMR          = 3,
  parameter int N              = 16,
  parameter int CNT_W          = 16,
  parameter int PERSIST_CYCLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [K_MMR-1:0][N-1:0] Q_i,
  input  logic                    mismatch_i,
  input  logic                    clear_i,
  output logic [CNT_W-1:0]        err_count_o,
  output logic                    sticky_o,
  output logic                    irq_o,
  output logic                    persistent_o,
  output logic [K_MMR-1:0]        lane_fault_o
);
  localparam int RW = $clog2(PERSIST_CYCLES + 1);

  if (K_MMR != 1 && K_MMR != 3) begin : g_bad_k
    $error("K_MMR must be 1 or 3");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end
  if (PERSIST_CYCLES < 2) begin : g_bad_persist
    $error("PERSIST_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    TRANSIENT,
    PERSISTENT
  } state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    run_q, run_d;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             irq_q;
  logic             ev;
  logic [K_MMR-1:0] lf_q;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    ev      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mis_q) begin
          state_d = TRANSIENT;
          run_d   = RW'(1);
          ev      = 1'b1;
        end
      end
      TRANSIENT: begin
        if (!mis_q) begin
          state_d = IDLE;
        end else if (run_q == RW'(PERSIST_CYCLES - 1)) begin
          state_d = PERSISTENT;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      PERSISTENT: begin
        if (!mis_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A new event overrides a coincident clear.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clear_i) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end
    if (ev) begin
      sticky_d = 1'b1;
      if (clear_i) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      run_q    <= '0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      mis_q    <= mismatch_i;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      irq_q    <= ev;
    end
  end

`ifdef MMR_MONITOR_LANE_DIAG_EN
  if (K_MMR == 3) begin : g_diag
    logic [K_MMR-1:0][N-1:0] q_q;
    logic [N-1:0]            maj;
    logic [K_MMR-1:0]        lf_d;

    always_comb begin
      maj  = (q_q[0] & q_q[1]) | (q_q[0] & q_q[2]) | (q_q[1] & q_q[2]);
      lf_d = clear_i ? '0 : lf_q;
      for (int k = 0; k < K_MMR; k++) begin
        if (mis_q && (q_q[k] != maj)) lf_d[k] = 1'b1;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        q_q  <= '0;
        lf_q <= '0;
      end else begin
        q_q  <= Q_i;
        lf_q <= lf_d;
      end
    end
  end else begin : g_nodiag
    logic unused_q;
    assign unused_q = ^Q_i;
    assign lf_q     = '0;
  end
`else
  logic unused_q;
  assign unused_q = ^Q_i;
  assign lf_q     = '0;
`endif

  assign err_count_o  = cnt_q;
  assign sticky_o     = sticky_q;
  assign irq_o        = irq_q;
  assign persistent_o = (state_q == PERSISTENT);
  assign lane_fault_o = lf_q;
endmodule

// File: tb/tb_mmr_mismatch_monitor.sv
// tb_mmr_mismatch_monitor: directed and random checks against a sample-history model.
// Lane expectations follow MMR_MONITOR_LANE_DIAG_EN.
module tb_mmr_mismatch_monitor;
  localparam int P = 4;
`ifdef MMR_MONITOR_LANE_DIAG_EN
  localparam bit DIAG = 1'b1;
`else
  localparam bit DIAG = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             mm = 1'b0;
  logic             clr = 1'b0;
  logic [2:0][15:0] q_in = '0;
  logic [15:0]      cnt;
  logic [1:0]       cnt2;
  logic             sticky, irq, pers, sticky2, irq2, pers2;
  logic [2:0]       lf, lf2;

  int n_checks = 0;
  int n_fail   = 0;

  bit               m_hist[$];
  logic [2:0][15:0] q_hist[$];
  int               e_cnt, e_cnt2;
  bit               e_sticky, e_irq, e_pers;
  logic [2:0]       e_lf;

  always #5 clk = ~clk;

  mmr_mismatch_monitor #(.K_MMR(3), .N(16), .CNT_W(16), .PERSIST_CYCLES(P)) dut (
    .clk_i(clk), .rst_i(rst_i), .Q_i(q_in), .mismatch_i(mm), .clear_i(clr),
    .err_count_o(cnt), .sticky_o(sticky), .irq_o(irq),
    .persistent_o(pers), .lane_fault_o(lf)
  );

  mmr_mismatch_monitor #(.K_MMR(3), .N(16), .CNT_W(2), .PERSIST_CYCLES(P)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .Q_i(q_in), .mismatch_i(mm), .clear_i(clr),
    .err_count_o(cnt2), .sticky_o(sticky2), .irq_o(irq2),
    .persistent_o(pers2), .lane_fault_o(lf2)
  );

  task automatic model_reset();
    m_hist.delete();
    q_hist.delete();
    e_cnt = 0; e_cnt2 = 0;
    e_sticky = 0; e_irq = 0; e_pers = 0;
    e_lf = '0;
  endtask

  // Event: newest stored sample 1, the one before 0. Persistent: last P samples all 1.
  task automatic model_step();
    int n, s;
    bit m1, m2, ev, allp;
    logic [2:0] upd;
    logic [15:0] maj;
    logic [2:0][15:0] w;
    if (rst_i) begin
      model_reset();
      return;
    end
    n = m_hist.size();
    m1 = (n >= 1) ? m_hist[n-1] : 1'b0;
    m2 = (n >= 2) ? m_hist[n-2] : 1'b0;
    ev = m1 && !m2;
    allp = (n >= P);
    for (int i = 1; i <= P; i++) if (i <= n && !m_hist[n-i]) allp = 0;
    upd = '0;
    if (m1 && DIAG) begin
      w = q_hist[n-1];
      for (int b = 0; b < 16; b++) begin
        s = int'(w[0][b]) + int'(w[1][b]) + int'(w[2][b]);
        maj[b] = (s >= 2);
      end
      for (int k = 0; k < 3; k++) upd[k] = (w[k] != maj);
    end
    e_irq = ev;
    e_pers = allp;
    if (ev) begin
      e_sticky = 1;
      e_cnt  = clr ? 1 : (e_cnt  < 65535 ? e_cnt + 1  : e_cnt);
      e_cnt2 = clr ? 1 : (e_cnt2 < 3     ? e_cnt2 + 1 : e_cnt2);
    end else if (clr) begin
      e_cnt = 0; e_cnt2 = 0; e_sticky = 0;
    end
    e_lf = (clr ? 3'b000 : e_lf) | upd;
    m_hist.push_back(mm);
    q_hist.push_back(q_in);
    if (m_hist.size() > P + 2) begin
      void'(m_hist.pop_front());
      void'(q_hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1; mm = 0; clr = 0; q_in = '0;
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; mm = 1; clr = 0; q_in = '0;
    tick(); tick();
    n_checks++;
    if ({cnt, sticky, irq, pers, lf} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outs got=%h exp=0", {cnt, sticky, irq, pers, lf});
    end
    n_checks++;
    if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_cnt2 got=%0d exp=0", cnt2); end
    rst_i = 0;
    tick();
    n_checks++;
    if (cnt !== 16'd0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL reset_e0 cnt=%0d irq=%b exp 0/0", cnt, irq);
    end
    tick();
    n_checks++;
    if (cnt !== 16'd1 || irq !== 1'b1 || sticky !== 1'b1) begin
      n_fail++; $display("FAIL reset_e1 cnt=%0d irq=%b sticky=%b exp 1/1/1", cnt, irq, sticky);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0 || cnt !== 16'd1) begin
      n_fail++; $display("FAIL reset_e2 irq=%b cnt=%0d exp 0/1", irq, cnt);
    end
    mm = 0;
    repeat (3) tick();
  endtask

  task automatic test_single_pulse();
    logic [2:0] exp_lf;
    do_reset();
    exp_lf = DIAG ? 3'b010 : 3'b000;
    q_in[1] = 16'h0001;
    mm = 1;
    tick();
    mm = 0; q_in = '0;
    tick();
    n_checks++;
    if (cnt !== 16'd1 || sticky !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL pulse_evt cnt=%0d sticky=%b irq=%b exp 1/1/1", cnt, sticky, irq);
    end
    n_checks++;
    if (lf !== exp_lf) begin n_fail++; $display("FAIL pulse_lane got=%b exp=%b", lf, exp_lf); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (irq !== 1'b0 || pers !== 1'b0 || cnt !== 16'd1) begin
        n_fail++; $display("FAIL pulse_after%0d irq=%b pers=%b cnt=%0d", i, irq, pers, cnt);
      end
    end
  endtask

  task automatic test_persistence();
    do_reset();
    mm = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (pers !== (i >= P)) begin
        n_fail++; $display("FAIL persist_rise e%0d got=%b exp=%b", i, pers, (i >= P));
      end
    end
    n_checks++;
    if (cnt !== 16'd1) begin n_fail++; $display("FAIL persist_cnt got=%0d exp=1", cnt); end
    mm = 0;
    tick();
    n_checks++;
    if (pers !== 1'b1) begin n_fail++; $display("FAIL persist_hold got=%b exp=1", pers); end
    tick();
    n_checks++;
    if (pers !== 1'b0) begin n_fail++; $display("FAIL persist_fall got=%b exp=0", pers); end
    mm = 1;
    tick(); tick();
    n_checks++;
    if (cnt !== 16'd2 || irq !== 1'b1) begin
      n_fail++; $display("FAIL persist_reassert cnt=%0d irq=%b exp 2/1", cnt, irq);
    end
    mm = 0;
    repeat (3) tick();
  endtask

  task automatic test_saturation();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      mm = 1; tick(); pulses += int'(irq2);
      mm = 0; tick(); pulses += int'(irq2);
      tick(); pulses += int'(irq2);
    end
    tick(); pulses += int'(irq2);
    n_checks++;
    if (cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got=%0d exp=3", cnt2); end
    n_checks++;
    if (pulses != 5) begin n_fail++; $display("FAIL sat_irqs got=%0d exp=5", pulses); end
    n_checks++;
    if (cnt !== 16'd5) begin n_fail++; $display("FAIL sat_wide got=%0d exp=5", cnt); end
  endtask

  task automatic test_clear();
    do_reset();
    mm = 1; tick();
    mm = 0; tick(); tick(); tick();
    mm = 1; tick();
    mm = 0; clr = 1; tick();
    clr = 0;
    n_checks++;
    if (cnt !== 16'd1 || sticky !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL clear_evt cnt=%0d sticky=%b irq=%b exp 1/1/1", cnt, sticky, irq);
    end
    tick(); tick();
    mm = 1;
    repeat (6) tick();
    n_checks++;
    if (pers !== 1'b1 || cnt !== 16'd2) begin
      n_fail++; $display("FAIL clear_pre pers=%b cnt=%0d exp 1/2", pers, cnt);
    end
    clr = 1; tick();
    clr = 0;
    n_checks++;
    if (cnt !== 16'd0 || sticky !== 1'b0 || pers !== 1'b1 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pers cnt=%0d sticky=%b pers=%b irq=%b exp 0/0/1/0", cnt, sticky, pers, irq);
    end
    tick();
    n_checks++;
    if (irq !== 1'b0 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL clear_norecount irq=%b cnt=%0d exp 0/0", irq, cnt);
    end
    mm = 0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic [15:0] base;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 3 == 0) mm = ~mm;
      clr = ($urandom % 20 == 0);
      base = 16'($urandom);
      q_in = {base, base, base};
      case ($urandom % 4)
        1: q_in[$urandom % 3] ^= 16'(1 << ($urandom % 16));
        2: q_in = {16'($urandom), 16'($urandom), 16'($urandom)};
        default: ;
      endcase
      tick();
      n_checks++;
      if (cnt !== 16'(e_cnt) || cnt2 !== 2'(e_cnt2)) begin
        n_fail++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, cnt, cnt2, e_cnt, e_cnt2);
      end
      n_checks++;
      if (sticky !== e_sticky || irq !== e_irq) begin
        n_fail++; $display("FAIL rnd_flags c=%0d sticky=%b irq=%b exp %b/%b", c, sticky, irq, e_sticky, e_irq);
      end
      n_checks++;
      if (pers !== e_pers || pers2 !== e_pers) begin
        n_fail++; $display("FAIL rnd_pers c=%0d got=%b/%b exp=%b", c, pers, pers2, e_pers);
      end
      n_checks++;
      if (lf !== e_lf) begin n_fail++; $display("FAIL rnd_lane c=%0d got=%b exp=%b", c, lf, e_lf); end
      if (c == 200) begin
        #2 rst_i = 1;
        #1;
        n_checks++;
        if ({cnt, sticky, irq, pers, lf, cnt2} !== 23'd0) begin
          n_fail++; $display("FAIL rnd_async_rst got=%h exp=0", {cnt, sticky, irq, pers, lf, cnt2});
        end
        model_reset();
        tick();
        rst_i = 0;
      end
    end
    clr = 0; mm = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_pulse();
    test_persistence();
    test_saturation();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
